alu_share_arb: RTL and testbench

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

---
 rtl/alu_share_arb_if.sv | 35 +++
 rtl/alu_share_arb.sv | 120 ++++++++++++
 tb/tb_alu_share_arb.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arb_if.sv
// Requester-side bus for the shared ALU arbiter: two request channels and
// two response channels, with each field packed as {req1, req0}.
//
// Handshake: a request moves when req_valid[i] & req_ready[i] are both high
// at a rising clock edge. A response moves when rsp_valid[i] & rsp_ready[i]
// are both high at a rising clock edge. A requester holds its request fields
// stable while req_valid[i] is high and ready is low. The arbiter holds
// rsp_data and rsp_zero stable while rsp_valid is high and ready is low.
interface alu_share_arb_if #(
  parameter int XLEN = 32
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [13:0]         req_opcode;
  logic [5:0]          req_func3;
  logic [13:0]         req_func7;
  logic [2*XLEN-1:0]   req_op1;
  logic [2*XLEN-1:0]   req_op2;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [XLEN-1:0]     rsp_data;
  logic                rsp_zero;

  modport master (
    output req_valid, req_opcode, req_func3, req_func7, req_op1, req_op2,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero
  );

  modport slave (
    input  req_valid, req_opcode, req_func3, req_func7, req_op1, req_op2,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero
  );
endinterface

// File: rtl/alu_share_arb.sv
// Two-requester round-robin front end for one shared combinational ALU.
// A granted request is registered onto the alu_* outputs, the ALU result is
// captured one cycle later, and it is then held as a response until the
// owning requester accepts it.
module alu_share_arb #(
  parameter int XLEN = 32,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_share_arb_if.slave    bus,
  output logic [6:0]        alu_opcode,
  output logic [2:0]        alu_func3,
  output logic [6:0]        alu_func7,
  output logic [XLEN-1:0]   alu_operand1,
  output logic [XLEN-1:0]   alu_operand2,
  input  logic [XLEN-1:0]   alu_out,
  input  logic              alu_zero,
  output logic              busy,
  output logic [CNTW-1:0]   op_count,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic   rr;
  logic   owner;
  logic   grant;
  logic   any_valid;
  logic   xfer;
  logic   rsp_fire;

  // The rr requester wins when it is asking; otherwise the other one does.
  assign any_valid = |bus.req_valid;
  assign grant     = bus.req_valid[rr] ? rr : ~rr;
  assign xfer      = (state == IDLE) && any_valid;
  assign rsp_fire  = (state == RESP) && bus.rsp_ready[owner];
  assign fsm_state = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: IDLE -> EXEC on a grant, EXEC -> RESP unconditionally,
  // RESP -> IDLE when the owner accepts.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_valid) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (rsp_fire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs. req_ready is gated by rst_n so no grant is shown while
  // reset is held, even if requesters are already asserting valid.
  always_comb begin
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && any_valid) bus.req_ready = grant ? 2'b10 : 2'b01;
      end
      EXEC: busy = 1'b1;
      RESP: begin
        busy          = 1'b1;
        bus.rsp_valid = owner ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

  // Datapath: latch the granted request, capture the ALU result, and on
  // completion advance the round-robin pointer and the completion counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode   <= '0;
      alu_func3    <= '0;
      alu_func7    <= '0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      owner        <= 1'b0;
      rr           <= 1'b0;
      bus.rsp_data <= '0;
      bus.rsp_zero <= 1'b0;
      op_count     <= '0;
    end else begin
      if (xfer) begin
        alu_opcode   <= grant ? bus.req_opcode[13:7] : bus.req_opcode[6:0];
        alu_func3    <= grant ? bus.req_func3[5:3]   : bus.req_func3[2:0];
        alu_func7    <= grant ? bus.req_func7[13:7]  : bus.req_func7[6:0];
        alu_operand1 <= grant ? bus.req_op1[2*XLEN-1:XLEN] : bus.req_op1[XLEN-1:0];
        alu_operand2 <= grant ? bus.req_op2[2*XLEN-1:XLEN] : bus.req_op2[XLEN-1:0];
        owner        <= grant;
      end
      if (state == EXEC) begin
        bus.rsp_data <= alu_out;
        bus.rsp_zero <= alu_zero;
      end
      if (rsp_fire) begin
        rr       <= ~owner;
        op_count <= op_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: a small R-type ALU model sits on the alu_* port,
// a transaction-level model predicts every output each cycle, and directed
// sequences pin the documented scenarios with literal values.
module tb_alu_share_arb;

  localparam int XLEN = 32;
  localparam int CNTW = 8;
  localparam logic [6:0] OP_R = 7'b0110011;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT and ALU model ----------------
  alu_share_arb_if #(.XLEN(XLEN)) bus ();

  logic [6:0]      alu_opcode;
  logic [2:0]      alu_func3;
  logic [6:0]      alu_func7;
  logic [XLEN-1:0] alu_operand1;
  logic [XLEN-1:0] alu_operand2;
  logic [XLEN-1:0] alu_out;
  logic            alu_zero;
  logic            busy;
  logic [CNTW-1:0] op_count;
  logic [1:0]      fsm_state;
  logic [XLEN-1:0] alu_bias = '0;

  logic [1:0][6:0]      r_opc;
  logic [1:0][2:0]      r_f3;
  logic [1:0][6:0]      r_f7;
  logic [1:0][XLEN-1:0] r_a;
  logic [1:0][XLEN-1:0] r_b;

  assign bus.req_opcode = r_opc;
  assign bus.req_func3  = r_f3;
  assign bus.req_func7  = r_f7;
  assign bus.req_op1    = r_a;
  assign bus.req_op2    = r_b;

  function automatic logic [XLEN-1:0] alu_fn(input logic [6:0] opc, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    if (opc != OP_R) return '0;
    case (f3)
      3'd0:    return f7[5] ? a - b : a + b;
      3'd4:    return a ^ b;
      3'd6:    return a | b;
      3'd7:    return a & b;
      default: return a + b;
    endcase
  endfunction

  assign alu_out  = alu_fn(alu_opcode, alu_func3, alu_func7, alu_operand1, alu_operand2) ^ alu_bias;
  assign alu_zero = (alu_out == '0);

  alu_share_arb #(.XLEN(XLEN), .CNTW(CNTW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alu_opcode   (alu_opcode),
    .alu_func3    (alu_func3),
    .alu_func7    (alu_func7),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .busy         (busy),
    .op_count     (op_count),
    .fsm_state    (fsm_state)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model + scoreboard ----------------
  // Model view: idle, or holding one accepted request m_age cycles old.
  // The response is due from age 2 until the owner accepts it.
  logic [XLEN:0]   exp_q[$];
  bit              m_active;
  int              m_age;
  bit              m_owner;
  bit              m_rr;
  logic [CNTW-1:0] m_count;
  logic [80:0]     m_alu;
  bit              m_g;
  logic [1:0]      e_ready;
  logic [1:0]      e_valid;
  logic [XLEN-1:0] m_res;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 0;
      m_age    = 0;
      m_owner  = 0;
      m_rr     = 0;
      m_count  = '0;
      m_alu    = '0;
      exp_q.delete();
    end else begin
      m_g     = bus.req_valid[m_rr] ? m_rr : !m_rr;
      e_ready = 2'b00;
      e_valid = 2'b00;
      if (!m_active && (bus.req_valid != 2'b00)) e_ready = m_g ? 2'b10 : 2'b01;
      if (m_active && m_age >= 2) e_valid = m_owner ? 2'b10 : 2'b01;
      chk("m_req_ready", 96'(bus.req_ready), 96'(e_ready));
      chk("m_rsp_valid", 96'(bus.rsp_valid), 96'(e_valid));
      chk("m_busy", 96'(busy), 96'(m_active));
      chk("m_op_count", 96'(op_count), 96'(m_count));
      chk("m_alu_fields", 96'({alu_opcode, alu_func3, alu_func7, alu_operand1, alu_operand2}),
          96'(m_alu));
      if (e_valid != 2'b00) begin
        if (exp_q.size() == 0) chk("m_rsp_queue_empty", 96'(1), 96'(0));
        else chk("m_rsp_payload", 96'({bus.rsp_zero, bus.rsp_data}), 96'(exp_q[0]));
      end
      // advance the model to the next cycle
      if (m_active) begin
        if (m_age >= 2 && bus.rsp_ready[m_owner]) begin
          m_active = 0;
          m_rr     = !m_owner;
          m_count  = m_count + 1'b1;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (m_age < 3) begin
          m_age++;
        end
      end else if (bus.req_valid != 2'b00) begin
        m_active = 1;
        m_age    = 1;
        m_owner  = m_g;
        m_alu    = {r_opc[m_g], r_f3[m_g], r_f7[m_g], r_a[m_g], r_b[m_g]};
        m_res    = alu_fn(r_opc[m_g], r_f3[m_g], r_f7[m_g], r_a[m_g], r_b[m_g]);
        exp_q.push_back({(m_res == '0), m_res});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    r_opc[i] = OP_R;
    r_f3[i]  = f3;
    r_f7[i]  = f7;
    r_a[i]   = a;
    r_b[i]   = b;
  endtask

  // Reset held across one falling edge so the model also restarts.
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.rsp_valid == 2'b00 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) chk({name, "_timeout"}, 96'(1), 96'(0));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_req_ready"}, 96'(bus.req_ready), 96'(0));
    chk({name, "_rsp_valid"}, 96'(bus.rsp_valid), 96'(0));
    chk({name, "_busy"}, 96'(busy), 96'(0));
    chk({name, "_op_count"}, 96'(op_count), 96'(0));
    chk({name, "_state"}, 96'(fsm_state), 96'(0));
    chk({name, "_rsp"}, 96'({bus.rsp_zero, bus.rsp_data}), 96'(0));
    chk({name, "_alu"}, 96'({alu_opcode, alu_func3, alu_func7, alu_operand1, alu_operand2}),
        96'(0));
  endtask

  // ---------------- directed sequences ----------------
  initial begin
    int n;
    r_opc = '0; r_f3 = '0; r_f7 = '0; r_a = '0; r_b = '0;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b00;
    #1;
    chk_all_zero("reset");
    bus.req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // single ADD 5+7 from requester 0
    tick();
    set_req(0, 3'd0, 7'd0, 32'd5, 32'd7);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    chk("add_req_ready", 96'(bus.req_ready), 96'(2'b01));
    tick();
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("add_exec_rsp_valid", 96'(bus.rsp_valid), 96'(0));
    @(negedge clk);
    chk("add_rsp_valid", 96'(bus.rsp_valid), 96'(2'b01));
    chk("add_rsp_data", 96'(bus.rsp_data), 96'(12));
    chk("add_rsp_zero", 96'(bus.rsp_zero), 96'(0));
    tick();
    @(negedge clk);
    chk("add_op_count", 96'(op_count), 96'(1));

    // both requesters held valid: grants alternate 0,1,0
    do_reset();
    tick();
    set_req(0, 3'd0, 7'd0, 32'd1, 32'd2);
    set_req(1, 3'd4, 7'd0, 32'hF0, 32'h0F);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      @(negedge clk);
      while (bus.req_ready == 2'b00 && n < 8) begin
        @(negedge clk);
        n++;
      end
      chk("rr_grant", 96'(bus.req_ready), 96'((k == 1) ? 2'b10 : 2'b01));
      tick();
    end
    bus.req_valid = 2'b00;
    repeat (4) tick();
    chk("rr_op_count", 96'(op_count), 96'(3));

    // response stall with ALU output disturbed: response must hold
    set_req(1, 3'd6, 7'd0, 32'h30, 32'h05);
    bus.req_valid = 2'b10;
    bus.rsp_ready = 2'b00;
    wait_rsp("stall");
    chk("stall_first_data", 96'(bus.rsp_data), 96'(32'h35));
    tick();
    alu_bias      = '1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b01;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_rsp_valid", 96'(bus.rsp_valid), 96'(2'b10));
      chk("stall_rsp_data", 96'(bus.rsp_data), 96'(32'h35));
      chk("stall_rsp_zero", 96'(bus.rsp_zero), 96'(0));
      chk("stall_req_ready", 96'(bus.req_ready), 96'(0));
      chk("stall_busy", 96'(busy), 96'(1));
      tick();
    end
    bus.req_valid = 2'b00;
    alu_bias      = '0;
    bus.rsp_ready = 2'b10;
    tick();
    @(negedge clk);
    chk("stall_done_busy", 96'(busy), 96'(0));
    chk("stall_op_count", 96'(op_count), 96'(4));

    // zero result: SUB 9-9
    tick();
    set_req(0, 3'd0, 7'b0100000, 32'd9, 32'd9);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    wait_rsp("sub");
    chk("sub_rsp_zero", 96'(bus.rsp_zero), 96'(1));
    chk("sub_rsp_data", 96'(bus.rsp_data), 96'(0));
    repeat (2) tick();

    // reset pulsed mid-EXEC: outputs clear without a clock edge, no response
    set_req(0, 3'd0, 7'd0, 32'd3, 32'd4);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b00;
    @(posedge clk);
    #2;
    chk("abort_in_exec", 96'(fsm_state), 96'(1));
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    chk_all_zero("abort");
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", 96'(bus.rsp_valid), 96'(0));
    end
    chk("abort_op_count", 96'(op_count), 96'(0));

    // counter wrap at 2^CNTW
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    n = 0;
    @(negedge clk);
    while (op_count != {CNTW{1'b1}} && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_at_max", 96'(op_count), 96'({CNTW{1'b1}}));
    n = 0;
    while (op_count == {CNTW{1'b1}} && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_to_zero", 96'(op_count), 96'(0));
    bus.req_valid = 2'b00;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
